pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Generic, parametrised pipeline register for the 5-stage core. It replaces fixed per-stage latches (ID/EX style) with a valid/ready elastic stage backed by a two-entry skid buffer. Upstream can be stalled without a combinational ready path. It carries separate datapath and control payloads. Flush turns the stage into a bubble with a configurable control encoding, and a saturating stall counter is kept for performance debug.

Parameters:
DATA_WIDTH, 64, datapath payload width (operands, immediate, PC, register indices packed by instantiator)
CTRL_WIDTH, 8, control payload width (branch/memread/memwrite/regwrite/aluop… packed)
CTRL_BUBBLE, {CTRL_WIDTH{1'b0}}, control value presented whenever out_valid=0
CLEAR_DATA_ON_FLUSH, 0, 1 = data registers zeroed on flush; 0 = data held (power saving)
CNT_WIDTH, 16, width of stall_count

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept; registered (function of state only)
in_data  input  DATA_WIDTH  upstream datapath payload
in_ctrl  input  CTRL_WIDTH  upstream control payload
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_data  output  DATA_WIDTH  head datapath payload
out_ctrl  output  CTRL_WIDTH  head control payload; CTRL_BUBBLE when out_valid=0
occupancy  output  2  entries held (0,1,2)
stall_count  output  CNT_WIDTH  cycles with in_valid=1 and in_ready=0, saturating

Behaviour:
- Storage: main register (drives out_*) and skid register. States EMPTY(occ 0), ONE(occ 1), FULL(occ 2).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = (state != FULL). out_valid = (state != EMPTY). out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE. out_data = main_data always.
- Transitions (flush=0):
  - EMPTY: accept → ONE, main<=in.
  - ONE: accept&!drain → FULL, skid<=in. accept&drain → ONE, main<=in. !accept&drain → EMPTY. Otherwise hold.
  - FULL: drain → ONE, main<=skid. Otherwise hold. No accept is possible in FULL.
- Latency: input accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY, or ONE with simultaneous drain. Throughput is 1/cycle with out_ready held high.
- Order: strict FIFO. No entry is dropped or duplicated except on flush.
- Flush has priority over all transitions. Next state = EMPTY, regardless of accept/drain in the same cycle.
- A handshake completed in a flush cycle counts as consumed and is discarded.
- The downstream drain in the flush cycle is still a valid transfer.
- With CLEAR_DATA_ON_FLUSH=1, main and skid data are zeroed on flush. With 0, they hold their values.
- stall_count increments by 1 each cycle with in_valid=1 & in_ready=0. It saturates at all-ones, never wraps, and is unaffected by flush. It is cleared only by reset.
- Reset (reset_n=0, asynchronous assert, output takes effect immediately):
  - state EMPTY, occupancy 0, out_valid 0, in_ready 1.
  - out_ctrl CTRL_BUBBLE, out_data 0, skid 0, stall_count 0.
  - Reset mid-transfer discards all entries.
  - Deassertion is synchronised externally. The first edge after deassert may accept.
- in_ready never depends combinationally on out_ready or flush.

Test Plan:
1. Reset check: hold reset_n=0 with in_valid=1, in_data=0xAA. Required response: out_valid=0, in_ready=1, occupancy=0, out_ctrl=CTRL_BUBBLE, out_data=0, stall_count=0. Assert reset_n asynchronously between edges and confirm outputs clear without waiting for a clock edge.
2. Streaming: out_ready=1, push data 0x11, 0x22, 0x33 with ctrl 0x81, 0x82, 0x83 on consecutive cycles. Required response: each appears exactly one cycle later, in_ready stays 1, occupancy stays ≤1.
3. Backpressure: out_ready=0, push A=0x1, B=0x2, then offer C=0x3 for 3 cycles. Required response: occupancy=2, in_ready=0, stall_count=3, out_data=0x1. Then set out_ready=1: outputs A, B, C in order, C accepted once in_ready rises.
4. Flush while FULL with in_valid=1: next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0, in_ready=1, and the offered input does not appear. Repeat with CLEAR_DATA_ON_FLUSH=1 and require out_data=0.
5. Simultaneous accept and drain in ONE: head 0x5, push 0x6 with out_ready=1. Required response: next cycle out_data=0x6, occupancy=1, skid unused. Also pulse reset_n low while FULL: occupancy becomes 0 immediately and previous entries are never output.
6. Saturation with CNT_WIDTH=4: stall for 20 cycles. Required response: stall_count=15 and holds there. A subsequent flush leaves it at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer.
// in_ready is decoded from the state register only, so upstream never sees a combinational path from out_ready.
module pipe_stage_skid #(
    parameter int unsigned           DATA_WIDTH          = 64,
    parameter int unsigned           CTRL_WIDTH          = 8,
    parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE         = '0,
    parameter bit                    CLEAR_DATA_ON_FLUSH = 1'b0,
    parameter int unsigned           CNT_WIDTH           = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e                state;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic                  accept;
    logic                  drain;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign occupancy = 2'(state);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the payload registers are reset too, so out_data reads 0 rather than X after reset.
            state     <= ST_EMPTY;
            main_data <= '0;
            main_ctrl <= CTRL_BUBBLE;
            skid_data <= '0;
            skid_ctrl <= CTRL_BUBBLE;
        end else if (flush) begin
            // Flush wins over any same-cycle accept/drain; the accepted beat is discarded.
            state <= ST_EMPTY;
            if (CLEAR_DATA_ON_FLUSH) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_ONE;
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state     <= ST_FULL;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end else if (accept && drain) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state     <= ST_ONE;
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Saturating stall counter; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule
